// File: rtl/carfield_domain_seq_if.sv
// rtl/carfield_domain_seq_if.sv - request/ack/control bundle between the domain sequencer and its domains
interface carfield_domain_seq_if #(
    parameter int unsigned NumDomains = 6
) ();
    logic [NumDomains-1:0] req_en_i;
    logic [NumDomains-1:0] iso_ack_i;
    logic                  timeout_clr_i;
    logic [NumDomains-1:0] iso_o;
    logic [NumDomains-1:0] clk_en_o;
    logic [NumDomains-1:0] rst_no;
    logic [NumDomains-1:0] status_on_o;
    logic                  busy_o;
    logic [NumDomains-1:0] timeout_o;

    modport master (
        input  req_en_i, iso_ack_i, timeout_clr_i,
        output iso_o, clk_en_o, rst_no, status_on_o, busy_o, timeout_o
    );

    modport slave (
        output req_en_i, iso_ack_i, timeout_clr_i,
        input  iso_o, clk_en_o, rst_no, status_on_o, busy_o, timeout_o
    );
endinterface

// File: rtl/carfield_domain_seq.sv
// rtl/carfield_domain_seq.sv - round-robin power-up/down sequencer for the Carfield gateable subdomains
// One shared FSM walks a single domain through clock/reset/isolation ordering at a time.
module carfield_domain_seq #(
    parameter int unsigned NumDomains       = 6,
    parameter int unsigned RstHoldCycles    = 16,
    parameter int unsigned IsoTimeoutCycles = 255,
    parameter int unsigned CntWidth         = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    carfield_domain_seq_if.master       bus
);
    localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] IsoLast  = CntWidth'(IsoTimeoutCycles - 1);

    typedef enum logic [2:0] {IDLE, UP_HOLD, UP_DEISO, DN_ISO, DN_HOLD} state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]       ptr_q, ptr_d, cur_q, cur_d;
    logic [IdxW-1:0]       grant_idx, scan_idx;
    logic                  grant_vld;
    logic [NumDomains-1:0] pending;
    logic [NumDomains-1:0] clk_en_q, clk_en_d, rst_n_q, rst_n_d, iso_q, iso_d;
    logic [NumDomains-1:0] on_q, on_d, to_q, to_d;

    // First pending domain strictly after the last grant, wrapping around.
    always_comb begin
        pending   = bus.req_en_i ^ on_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 1; i <= int'(NumDomains); i++) begin
            scan_idx = IdxW'((int'(ptr_q) + i) % int'(NumDomains));
            if (!grant_vld && pending[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        clk_en_d = clk_en_q;
        rst_n_d  = rst_n_q;
        iso_d    = iso_q;
        on_d     = on_q;
        to_d     = bus.timeout_clr_i ? '0 : to_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ptr_d = grant_idx;
                    cur_d = grant_idx;
                    cnt_d = '0;
                    if (bus.req_en_i[grant_idx]) begin
                        clk_en_d[grant_idx] = 1'b1;
                        state_d             = UP_HOLD;
                    end else begin
                        iso_d[grant_idx] = 1'b1;
                        state_d          = DN_ISO;
                    end
                end
            end
            UP_HOLD: begin
                if (cnt_q == HoldLast) begin
                    rst_n_d[cur_q] = 1'b1;
                    state_d        = UP_DEISO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UP_DEISO: begin
                iso_d[cur_q] = 1'b0;
                on_d[cur_q]  = 1'b1;
                state_d      = IDLE;
            end
            DN_ISO: begin
                // An acknowledge on the timeout cycle still counts as a clean quiesce.
                if (bus.iso_ack_i[cur_q]) begin
                    rst_n_d[cur_q] = 1'b0;
                    cnt_d          = '0;
                    state_d        = DN_HOLD;
                end else if (cnt_q == IsoLast) begin
                    to_d[cur_q]    = 1'b1;
                    rst_n_d[cur_q] = 1'b0;
                    cnt_d          = '0;
                    state_d        = DN_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DN_HOLD: begin
                if (cnt_q == HoldLast) begin
                    clk_en_d[cur_q] = 1'b0;
                    on_d[cur_q]     = 1'b0;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= IdxW'(NumDomains - 1);
            cur_q    <= '0;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            iso_q    <= '1;
            on_q     <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            clk_en_q <= clk_en_d;
            rst_n_q  <= rst_n_d;
            iso_q    <= iso_d;
            on_q     <= on_d;
            to_q     <= to_d;
        end
    end

    assign bus.clk_en_o    = clk_en_q;
    assign bus.rst_no      = rst_n_q;
    assign bus.iso_o       = iso_q;
    assign bus.status_on_o = on_q;
    assign bus.timeout_o   = to_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_carfield_domain_seq.sv
// tb/tb_carfield_domain_seq.sv - self-checking bench for carfield_domain_seq
module tb_carfield_domain_seq;
    localparam int N = 6;
    localparam int R = 16;
    localparam int T = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    carfield_domain_seq_if #(.NumDomains(N)) bus ();

    carfield_domain_seq #(
        .NumDomains(N), .RstHoldCycles(R), .IsoTimeoutCycles(T), .CntWidth(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Timeline model: each sequence is described by its grant edge and the edge reset was asserted.
    logic [N-1:0] m_clk, m_rstn, m_iso, m_on, m_to;
    logic         m_busy, m_up;
    int           m_dom, m_ptr, m_t0, m_rst_edge, m_edge, m_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clk = '0; m_rstn = '0; m_iso = '1; m_on = '0; m_to = '0;
            m_busy = 1'b0; m_up = 1'b0; m_ptr = N - 1; m_dom = 0;
            m_t0 = 0; m_rst_edge = -1; m_edge = 0;
        end else begin
            m_edge++;
            if (bus.timeout_clr_i) m_to = '0;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    m_d = (m_ptr + k) % N;
                    if (!m_busy && (bus.req_en_i[m_d] != m_on[m_d])) begin
                        m_busy = 1'b1; m_dom = m_d; m_ptr = m_d; m_t0 = m_edge;
                        m_up = bus.req_en_i[m_d]; m_rst_edge = -1;
                        if (m_up) m_clk[m_d] = 1'b1;
                        else      m_iso[m_d] = 1'b1;
                    end
                end
            end else if (m_up) begin
                if (m_edge == m_t0 + R) m_rstn[m_dom] = 1'b1;
                else if (m_edge == m_t0 + R + 1) begin
                    m_iso[m_dom] = 1'b0; m_on[m_dom] = 1'b1; m_busy = 1'b0;
                end
            end else if (m_rst_edge < 0) begin
                if (bus.iso_ack_i[m_dom]) begin
                    m_rstn[m_dom] = 1'b0; m_rst_edge = m_edge;
                end else if (m_edge == m_t0 + T) begin
                    m_rstn[m_dom] = 1'b0; m_to[m_dom] = 1'b1; m_rst_edge = m_edge;
                end
            end else if (m_edge == m_rst_edge + R) begin
                m_clk[m_dom] = 1'b0; m_on[m_dom] = 1'b0; m_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.req_en_i = '0; bus.iso_ack_i = '0; bus.timeout_clr_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.clk_en_o, bus.rst_no, bus.iso_o, bus.status_on_o, bus.timeout_o, bus.busy_o} !== {6'h00, 6'h00, 6'h3f, 6'h00, 6'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got clk=%b rstn=%b iso=%b on=%b to=%b busy=%b", bus.clk_en_o, bus.rst_no, bus.iso_o, bus.status_on_o, bus.timeout_o, bus.busy_o);
        end
    endtask

    task automatic test_power_up();
        bus.req_en_i = 6'b000001;
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 1) begin
                checks++;
                if (bus.clk_en_o !== 6'b000001 || bus.busy_o !== 1'b1) begin
                    errors++; $display("FAIL up_edge1: got clk=%b busy=%b want 000001/1", bus.clk_en_o, bus.busy_o);
                end
            end
            if (e == 16 || e == 17) begin
                checks++;
                if (bus.rst_no[0] !== (e == 17)) begin
                    errors++; $display("FAIL up_rst_release edge %0d: got %b want %b", e, bus.rst_no[0], (e == 17));
                end
            end
            if (e == 17 || e == 18) begin
                checks++;
                if ({bus.iso_o[0], bus.status_on_o[0], bus.busy_o} !== ((e == 18) ? 3'b010 : 3'b101)) begin
                    errors++; $display("FAIL up_deiso edge %0d: got iso/on/busy=%b%b%b", e, bus.iso_o[0], bus.status_on_o[0], bus.busy_o);
                end
            end
        end
    endtask

    task automatic test_power_down_ack();
        bus.req_en_i = 6'b001001;
        repeat (18) tick();
        checks++;
        if (bus.status_on_o !== 6'b001001 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL dn_setup: got on=%b busy=%b want 001001/0", bus.status_on_o, bus.busy_o);
        end
        bus.req_en_i = 6'b000001;
        for (int e = 1; e <= 22; e++) begin
            if (e == 6) bus.iso_ack_i = 6'b001000;
            tick();
            if (e == 6) bus.iso_ack_i = '0;
            if (e == 5 || e == 6) begin
                checks++;
                if (bus.rst_no[3] !== (e == 5)) begin
                    errors++; $display("FAIL dn_rst edge %0d: got %b want %b", e, bus.rst_no[3], (e == 5));
                end
            end
            if (e == 21 || e == 22) begin
                checks++;
                if ({bus.clk_en_o[3], bus.status_on_o[3], bus.busy_o} !== ((e == 21) ? 3'b111 : 3'b000)) begin
                    errors++; $display("FAIL dn_clk_gate edge %0d: got clk/on/busy=%b%b%b", e, bus.clk_en_o[3], bus.status_on_o[3], bus.busy_o);
                end
            end
        end
        checks++;
        if (bus.timeout_o !== 6'b0) begin
            errors++; $display("FAIL dn_no_timeout: got %b want 000000", bus.timeout_o);
        end
    endtask

    task automatic test_timeout();
        bus.req_en_i = 6'b000101;
        repeat (18) tick();
        bus.req_en_i = 6'b000001;
        bus.iso_ack_i = '0;
        for (int e = 1; e <= 272; e++) begin
            tick();
            if (e == 255 || e == 256) begin
                checks++;
                if ({bus.rst_no[2], bus.timeout_o} !== ((e == 255) ? 7'b1_000000 : 7'b0_000100)) begin
                    errors++; $display("FAIL to_edge %0d: got rstn=%b to=%b", e, bus.rst_no[2], bus.timeout_o);
                end
            end
            if (e == 271 || e == 272) begin
                checks++;
                if (bus.clk_en_o[2] !== (e == 271)) begin
                    errors++; $display("FAIL to_clk_gate edge %0d: got %b want %b", e, bus.clk_en_o[2], (e == 271));
                end
            end
        end
        bus.timeout_clr_i = 1'b1;
        tick();
        bus.timeout_clr_i = 1'b0;
        checks++;
        if (bus.timeout_o !== 6'b0) begin
            errors++; $display("FAIL to_clear: got %b want 000000", bus.timeout_o);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.req_en_i = 6'b100101;
        for (int e = 1; e <= 54; e++) begin
            tick();
            if (e == 1 || e == 19 || e == 37) begin
                checks++;
                if (bus.clk_en_o !== ((e == 1) ? 6'b000001 : (e == 19) ? 6'b000101 : 6'b100101)) begin
                    errors++; $display("FAIL rr_order edge %0d: got clk=%b", e, bus.clk_en_o);
                end
            end
            if (e == 18 || e == 36) begin
                checks++;
                if (bus.busy_o !== 1'b0) begin
                    errors++; $display("FAIL rr_idle_gap edge %0d: got busy=%b want 0", e, bus.busy_o);
                end
            end
        end
        checks++;
        if (bus.status_on_o !== 6'b100101) begin
            errors++; $display("FAIL rr_all_on: got %b want 100101", bus.status_on_o);
        end
        bus.iso_ack_i = '1;
        bus.req_en_i = 6'b100001;
        repeat (18) tick();
        bus.req_en_i = 6'b000000;
        for (int e = 1; e <= 36; e++) begin
            tick();
            if (e == 2 || e == 20) begin
                checks++;
                if (bus.rst_no !== ((e == 2) ? 6'b000001 : 6'b000000)) begin
                    errors++; $display("FAIL rr_wrap edge %0d: got rstn=%b", e, bus.rst_no);
                end
            end
        end
        bus.iso_ack_i = '0;
        checks++;
        if (bus.status_on_o !== 6'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL rr_all_off: got on=%b busy=%b", bus.status_on_o, bus.busy_o);
        end
    endtask

    task automatic test_reversal_reset();
        apply_reset();
        bus.req_en_i = 6'b000010;
        repeat (5) tick();
        bus.req_en_i = 6'b000000;
        repeat (13) tick();
        checks++;
        if (bus.status_on_o !== 6'b000010 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL rev_up_completes: got on=%b busy=%b", bus.status_on_o, bus.busy_o);
        end
        tick();
        checks++;
        if (bus.busy_o !== 1'b1 || bus.iso_o[1] !== 1'b1) begin
            errors++; $display("FAIL rev_down_starts: got busy=%b iso=%b", bus.busy_o, bus.iso_o[1]);
        end
        bus.iso_ack_i = 6'b000010;
        tick();
        bus.iso_ack_i = '0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.clk_en_o, bus.rst_no, bus.iso_o, bus.status_on_o, bus.timeout_o, bus.busy_o} !== {6'h00, 6'h00, 6'h3f, 6'h00, 6'h00, 1'b0}) begin
            errors++; $display("FAIL async_reset: got clk=%b rstn=%b iso=%b on=%b busy=%b", bus.clk_en_o, bus.rst_no, bus.iso_o, bus.status_on_o, bus.busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.clk_en_o !== 6'b0) begin
            errors++; $display("FAIL no_resume: got busy=%b clk=%b", bus.busy_o, bus.clk_en_o);
        end
    endtask

    task automatic test_random();
        logic [30:0] got, want;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 37 == 0) bus.req_en_i = N'($urandom);
            if ((c / 400) % 2 == 0) bus.iso_ack_i = N'($urandom) & N'($urandom) & N'($urandom);
            else                    bus.iso_ack_i = '0;
            bus.timeout_clr_i = ($urandom_range(0, 49) == 0);
            tick();
            got  = {bus.clk_en_o, bus.rst_no, bus.iso_o, bus.status_on_o, bus.timeout_o, bus.busy_o};
            want = {m_clk, m_rstn, m_iso, m_on, m_to, m_busy};
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL random cycle %0d: got %h want %h", c, got, want);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_en_i = '0; bus.iso_ack_i = '0; bus.timeout_clr_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_power_up();
        test_power_down_ack();
        test_timeout();
        test_round_robin();
        test_reversal_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/carfield_domain_seq.md
# carfield_domain_seq

Sequencer that powers the Carfield clock-gateable subdomains up and down: periph, safety island, security island, integer cluster, FP cluster and L2. It sits between the per-domain enable requests from the Carfield control registers and the per-domain clock-gate, reset and AXI-isolation controls. A single shared FSM serves one domain at a time. When several domains have a pending request, it picks the next one round-robin.

## Interface
Parameters:
- NumDomains, 6, number of sequenced domains; index matches the Carfield domain enumeration (periph = 0 … L2 = 5).
- RstHoldCycles, 16, cycles reset stays asserted with the clock running, on both power-up and power-down; must be ≥ 1.
- IsoTimeoutCycles, 255, maximum cycles to wait for an isolation acknowledge; must be ≥ 1.
- CntWidth, 8, width of the shared counter; must be ≥ $clog2(max(RstHoldCycles, IsoTimeoutCycles)).

Ports:
- clk_i  in  1  sequencer clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_en_i  in  NumDomains  requested state per domain, level: 1 = on, 0 = off.
- iso_ack_i  in  NumDomains  domain AXI boundary is quiesced and isolated.
- iso_o  out  NumDomains  isolation request to the domain's AXI boundary.
- clk_en_o  out  NumDomains  domain clock-gate enable.
- rst_no  out  NumDomains  domain reset, active-low.
- status_on_o  out  NumDomains  domain fully on.
- busy_o  out  1  sequencer is not idle.
- timeout_o  out  NumDomains  sticky flag: isolation acknowledge timed out.
- timeout_clr_i  in  1  clears all timeout_o bits.

## Operation
- **Reset values** (all domains off):
  - clk_en_o = 0, rst_no = 0, iso_o = all 1, status_on_o = 0, timeout_o = 0.
  - busy_o = 0, state = IDLE, counter = 0.
  - Round-robin pointer = NumDomains-1, so domain 0 wins first.
- **Pending request:** pending[d] = req_en_i[d] XOR status_on_o[d].
- **Arbitration:** in IDLE, grant the first pending index strictly after the pointer, wrapping around. On grant:
  - the pointer is set to the granted index;
  - the index is latched as cur.
- **Request changes:** req_en_i changes during a sequence are ignored until the FSM returns to IDLE, then re-evaluated. A request reversed mid-sequence therefore triggers the opposite sequence afterwards.
- **States:** IDLE, UP_HOLD, UP_DEISO, DN_ISO, DN_HOLD.
- **Power-up** (pending and req_en_i[cur] = 1):
  - IDLE→UP_HOLD: set clk_en_o[cur], clear the counter.
  - UP_HOLD: the counter increments each cycle. When counter = RstHoldCycles-1: set rst_no[cur], go to UP_DEISO.
  - UP_DEISO→IDLE after one cycle: clear iso_o[cur], set status_on_o[cur].
- **Power-down** (pending and req_en_i[cur] = 0):
  - IDLE→DN_ISO: iso_o[cur] is already 1 (set or kept), clear the counter.
  - DN_ISO, acknowledge path: if iso_ack_i[cur] = 1, clear rst_no[cur], clear the counter, go to DN_HOLD.
  - DN_ISO, timeout path: else if counter = IsoTimeoutCycles-1, set timeout_o[cur], clear rst_no[cur], go to DN_HOLD. Reset is forced even without an acknowledge.
  - DN_ISO otherwise: the counter increments.
  - DN_HOLD: when counter = RstHoldCycles-1: clear clk_en_o[cur] and status_on_o[cur], go to IDLE.
- **Output ordering:**
  - Power-up: clock on before reset release, and reset release before de-isolation.
  - Power-down: isolation before reset assertion, and reset assertion before clock gating.
- **Status outputs:**
  - busy_o = (state ≠ IDLE), decoded from the state register.
  - All other outputs are registered.
- **Timeout flags:** timeout_clr_i clears all timeout_o bits. If timeout_clr_i and a new timeout occur on the same edge, the new bit is set (set wins).
- **Reset mid-sequence:** rst_i at any time returns every output to its reset value immediately (asynchronously). No sequence is resumed after reset.

## Timing
- Edges are numbered from the first rising edge that samples the request (edge 1).
- **Power-up of an idle domain:**
  - edge 1: clk_en_o = 1, busy_o = 1;
  - edge RstHoldCycles+1: rst_no = 1;
  - edge RstHoldCycles+2: iso_o = 0, status_on_o = 1, busy_o = 0.
  - With defaults these are edges 1, 17 and 18.
- **Power-down:**
  - edge 1: enter DN_ISO; iso_ack_i is sampled from edge 2 onwards.
  - If the acknowledge is sampled high at edge k: rst_no = 0 at edge k; clk_en_o = 0, status_on_o = 0 and IDLE at edge k+RstHoldCycles.
  - Earliest completion: k = 2.
- **No acknowledge:** rst_no falls and timeout_o rises at edge 1+IsoTimeoutCycles.
- **Acknowledge and timeout on the same edge:** the acknowledge wins and timeout_o is not set.
- **Back-to-back grants:** the next grant happens on the edge after the return to IDLE, so there is one IDLE cycle between consecutive sequences.

## Test plan
- **Single power-up:** reset, then req_en_i = 6'b000001 → clk_en_o[0] at edge 1, rst_no[0] at edge 17, iso_o[0] = 0 and status_on_o[0] = 1 at edge 18; busy_o low from edge 18.
- **Power-down with acknowledge:** domain 3 on, req_en_i[3] = 0, iso_ack_i[3] raised 5 cycles later → rst_no[3] falls on the edge sampling the acknowledge; clk_en_o[3] falls 16 edges later; timeout_o = 0.
- **Timeout:** domain 2 on, drop its request, hold iso_ack_i = 0 → timeout_o[2] = 1 and rst_no[2] = 0 at edge 256; clk_en_o[2] = 0 at edge 272. Pulse timeout_clr_i → timeout_o = 0.
- **Round-robin:** from reset, req_en_i = 6'b100101 → domains serviced in order 0, 2, 5, with one IDLE cycle between sequences. Then requests for 5 and 0 arriving together while the pointer is at 2 → 5 first, then 0.
- **Reversal and reset:**
  - Drop req_en_i[1] mid UP_HOLD → the power-up completes, then a power-down runs.
  - Assert rst_i mid DN_HOLD → all outputs return to reset values asynchronously, and busy_o = 0.
